// File: rtl/dht_sensor_reader.sv
// DHT11/DHT22 single-wire reader: start pulse, response, 40-bit frame, checksum.
// Ports: clk, reset, data_io (open-drain), start, mode, busy, done, err_*, humidity, temperature, state_dbg.
module dht_sensor_reader #(
  parameter int CLOCK_FREQ    = 100_000_000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200,
  parameter int AUTO_POLL     = 0,
  parameter int POLL_MS       = 2000
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         data_io,
  input  logic        start,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  output logic        err_checksum,
  output logic        err_timeout,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic [3:0]  state_dbg
);

  localparam int DIV     = CLOCK_FREQ / 1_000_000;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int POLL_US = POLL_MS * 1000;
  localparam int PW      = $clog2(POLL_US + 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd1,
    START_LOW = 4'd2,
    RELEASE   = 4'd3,
    RESP_LOW  = 4'd4,
    RESP_HIGH = 4'd5,
    BIT_LOW   = 4'd6,
    BIT_HIGH  = 4'd7,
    CHECK     = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q;
  logic [14:0]   us_q, us_d;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic          mode_q, mode_d;
  logic [5:0]    bits_q, bits_d;
  logic [39:0]   shift_q, shift_d;
  logic [15:0]   hum_q, hum_d;
  logic [15:0]   temp_q, temp_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          errc_q, errc_d;
  logic          errt_q, errt_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          arm_q, arm_d;

  logic        tick, fall, rise, poll_fire, wait_st;
  logic [14:0] hold_us;
  logic [7:0]  b0, b1, b2, b3, b4, sum;
  logic [15:0] hum_v, mag_v, temp_v;
  logic        neg_v;

  assign tick = (div_q == DW'(DIV - 1));
  assign fall = prev_q & ~sync_q[1];
  assign rise = ~prev_q & sync_q[1];

  assign data_io = (state_q == START_LOW) ? 1'b0 : 1'bz;

  assign hold_us = mode_q ? 15'd1000 : 15'd18000;
  assign wait_st = state_q inside {RELEASE, RESP_LOW,
                                   RESP_HIGH, BIT_LOW, BIT_HIGH};

  // Timer is idle until the first done; only then does polling begin.
  assign poll_fire = (AUTO_POLL != 0) && arm_q && tick &&
                     (poll_q == PW'(POLL_US - 1));

  assign b0  = shift_q[39:32];
  assign b1  = shift_q[31:24];
  assign b2  = shift_q[23:16];
  assign b3  = shift_q[15:8];
  assign b4  = shift_q[7:0];
  assign sum = b0 + b1 + b2 + b3;

  always_comb begin
    if (mode_q) begin
      hum_v = {b0, b1};
      mag_v = {1'b0, b2[6:0], b3};
      neg_v = b2[7];
    end else begin
      hum_v = 16'(b0) * 16'd10 + 16'(b1[3:0]);
      mag_v = 16'(b2) * 16'd10 + 16'(b3[3:0]);
      neg_v = b3[7];
    end
    temp_v = neg_v ? (~mag_v + 16'd1) : mag_v;
  end

  always_comb begin
    state_d = state_q;
    us_d    = us_q;
    mode_d  = mode_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    hum_d   = hum_q;
    temp_d  = temp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    errc_d  = 1'b0;
    errt_d  = 1'b0;
    poll_d  = poll_q;
    arm_d   = arm_q;

    if (tick && us_q != '1) us_d = us_q + 15'd1;

    unique case (state_q)
      IDLE: begin
        if (!done_q && (start || poll_fire)) begin
          state_d = START_LOW;
          mode_d  = mode;
          bits_d  = '0;
          busy_d  = 1'b1;
        end
      end
      START_LOW: begin
        if (tick && us_q == hold_us - 15'd1)
          state_d = RELEASE;
      end
      RELEASE:   if (fall) state_d = RESP_LOW;
      RESP_LOW:  if (rise) state_d = RESP_HIGH;
      RESP_HIGH: if (fall) state_d = BIT_LOW;
      BIT_LOW:   if (rise) state_d = BIT_HIGH;
      BIT_HIGH: begin
        if (fall) begin
          shift_d = {shift_q[38:0],
                     us_q > 15'(BIT_THRESH_US)};
          bits_d  = bits_q + 6'd1;
          state_d = (bits_q == 6'd39) ? CHECK : BIT_LOW;
        end
      end
      CHECK: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (b4 == sum) begin
          hum_d  = hum_v;
          temp_d = temp_v;
        end else begin
          errc_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wait_st && us_q >= 15'(TIMEOUT_US)) begin
      state_d = IDLE;
      done_d  = 1'b1;
      errt_d  = 1'b1;
      busy_d  = 1'b0;
    end

    // Every state entry and every accepted edge restarts the us count.
    if (state_d != state_q || state_q == IDLE) us_d = '0;

    if (AUTO_POLL != 0) begin
      if (done_d) begin
        poll_d = '0;
        arm_d  = 1'b1;
      end else if (state_q == IDLE && arm_q && tick &&
                   poll_q != PW'(POLL_US - 1)) begin
        poll_d = poll_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      us_q    <= '0;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      mode_q  <= 1'b0;
      bits_q  <= '0;
      shift_q <= '0;
      hum_q   <= '0;
      temp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      errc_q  <= 1'b0;
      errt_q  <= 1'b0;
      poll_q  <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= tick ? '0 : div_q + DW'(1);
      us_q    <= us_d;
      sync_q  <= {sync_q[0], data_io};
      prev_q  <= sync_q[1];
      mode_q  <= mode_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      hum_q   <= hum_d;
      temp_q  <= temp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      errc_q  <= errc_d;
      errt_q  <= errt_d;
      poll_q  <= poll_d;
      arm_q   <= arm_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_checksum = errc_q;
  assign err_timeout  = errt_q;
  assign humidity     = hum_q;
  assign temperature  = temp_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_dht_sensor_reader.sv
// Bench for dht_sensor_reader: sensor model, expected-result queue, done monitor.
// Two instances: polled by start, and auto-poll with a 2 ms interval.
module tb_dht_sensor_reader;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] t;
    logic        ck;
    logic        to;
  } exp_t;

  localparam logic [39:0] FR11 = 40'h37_00_18_05_54;
  localparam logic [39:0] FR_A = 40'h02_8C_01_5F_EE;
  localparam logic [39:0] FR_B = 40'h02_8C_80_65_73;
  localparam logic [39:0] FR_C = 40'h02_8C_01_5F_EF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, mode0 = 1'b0;
  logic start1 = 1'b0, mode1 = 1'b0;
  logic sen0 = 1'b0, sen1 = 1'b0;
  wire  bus0, bus1;
  logic busy0, done0, ec0, et0;
  logic busy1, done1, ec1, et1;
  logic [15:0] hum0, tmp0, hum1, tmp1;
  logic [3:0]  st0, st1;

  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;

  assign bus0 = sen0 ? 1'b0 : 1'bz;
  assign bus1 = sen1 ? 1'b0 : 1'bz;
  pullup (bus0);
  pullup (bus1);

  always #5 clk = ~clk;

  dht_sensor_reader #(
    .CLOCK_FREQ(1_000_000)
  ) u0 (
    .clk(clk), .reset(reset), .data_io(bus0),
    .start(start0), .mode(mode0), .busy(busy0),
    .done(done0), .err_checksum(ec0), .err_timeout(et0),
    .humidity(hum0), .temperature(tmp0), .state_dbg(st0)
  );

  dht_sensor_reader #(
    .CLOCK_FREQ(1_000_000), .AUTO_POLL(1), .POLL_MS(2)
  ) u1 (
    .clk(clk), .reset(reset), .data_io(bus1),
    .start(start1), .mode(mode1), .busy(busy1),
    .done(done1), .err_checksum(ec1), .err_timeout(et1),
    .humidity(hum1), .temperature(tmp1), .state_dbg(st1)
  );

  function automatic exp_t mk(input logic [15:0] h,
                              input logic [15:0] t,
                              input logic ck, input logic to);
    exp_t e;
    e.h = h; e.t = t; e.ck = ck; e.to = to;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic mon(input string tag, input exp_t e,
                     input logic [15:0] h, input logic [15:0] t,
                     input logic ck, input logic to);
    chk({tag, "_hum"}, 32'(h), 32'(e.h));
    chk({tag, "_temp"}, 32'(t), 32'(e.t));
    chk({tag, "_err_ck"}, 32'(ck), 32'(e.ck));
    chk({tag, "_err_to"}, 32'(to), 32'(e.to));
  endtask

  always @(negedge clk) begin
    if (!reset && done0) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut0_done: got done want none");
      end else begin
        mon("dut0", q0.pop_front(), hum0, tmp0, ec0, et0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut1_done: got done want none");
      end else begin
        mon("dut1", q1.pop_front(), hum1, tmp1, ec1, et1);
      end
    end
  end

  function automatic logic rd(input int w);
    return (w != 0) ? bus1 : bus0;
  endfunction

  function automatic logic bsy(input int w);
    return (w != 0) ? busy1 : busy0;
  endfunction

  function automatic logic dn(input int w);
    return (w != 0) ? done1 : done0;
  endfunction

  function automatic logic [3:0] st(input int w);
    return (w != 0) ? st1 : st0;
  endfunction

  task automatic drv(input int w, input logic lo);
    if (w != 0) sen1 = lo;
    else sen0 = lo;
  endtask

  task automatic set_start(input int w, input logic v);
    if (w != 0) start1 = v;
    else start0 = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int w);
    @(negedge clk) set_start(w, 1'b1);
    @(negedge clk) set_start(w, 1'b0);
  endtask

  task automatic wait_done(input int w, input int bound,
                           output int n);
    n = 0;
    while (dn(w) !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done%0d: got no done want done in %0d",
               w, bound);
    end
  endtask

  // abort_bit < 0: never answer; 0..39: drop out during that bit.
  task automatic sensor(input int w, input logic [39:0] fr,
                        input int abort_bit, input int exp_low);
    int n;
    n = 0;
    while (rd(w) !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL start_seen%0d: got no low want low", w);
      return;
    end
    n = 0;
    while (rd(w) === 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (exp_low != 0)
      chk_rng("start_low_len", n, exp_low - 1, exp_low + 1);
    if (abort_bit < 0) return;
    wait_cyc(20);
    drv(w, 1'b1); wait_cyc(80);
    drv(w, 1'b0); wait_cyc(80);
    for (int k = 0; k < 40; k++) begin
      drv(w, 1'b1); wait_cyc(20);
      drv(w, 1'b0);
      if (k == abort_bit) begin
        wait_cyc(10);
        return;
      end
      wait_cyc(fr[39-k] ? 70 : 20);
    end
    drv(w, 1'b1);
  endtask

  task automatic finish_read(input int w, input bit sod);
    int n;
    wait_done(w, 60, n);
    if (sod) begin
      set_start(w, 1'b1);
      @(negedge clk) set_start(w, 1'b0);
    end
    wait_cyc(20);
    drv(w, 1'b0);
    chk("busy_after_done", 32'(bsy(w)), 32'd0);
    chk("state_after_done", 32'(st(w)), 32'd1);
  endtask

  task automatic do_read(input int w, input logic m,
                         input logic [39:0] fr, input exp_t e,
                         input int exp_low, input bit sod);
    if (w != 0) begin mode1 = m; q1.push_back(e); end
    else begin mode0 = m; q0.push_back(e); end
    pulse_start(w);
    chk("busy_after_start", 32'(bsy(w)), 32'd1);
    sensor(w, fr, 99, exp_low);
    finish_read(w, sod);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    wait_cyc(3);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_errs", 32'({ec0, et0}), 32'd0);
    chk("rst_hum", 32'(hum0), 32'd0);
    chk("rst_temp", 32'(tmp0), 32'd0);
    chk("rst_state", 32'(st0), 32'd1);
    chk("rst_bus", 32'(bus0), 32'd1);
    @(negedge clk) reset = 1'b0;
    wait_cyc(5);

    do_read(0, 1'b0, FR11, mk(16'd550, 16'd245, 0, 0), 18000, 0);
    do_read(0, 1'b1, FR_A, mk(16'd652, 16'd351, 0, 0), 1000, 1);
    do_read(0, 1'b1, FR_B, mk(16'd652, 16'hFF9B, 0, 0), 1000, 0);
    do_read(0, 1'b1, FR_C, mk(16'd652, 16'hFF9B, 1, 0), 1000, 0);

    mode0 = 1'b0;
    q0.push_back(mk(16'd652, 16'hFF9B, 0, 1));
    pulse_start(0);
    sensor(0, FR_A, -1, 18000);
    wait_done(0, 1000, n);
    chk_rng("release_to_timeout", n, 200, 202);
    @(negedge clk);
    chk("busy_after_timeout", 32'(busy0), 32'd0);

    mode0 = 1'b1;
    pulse_start(0);
    sensor(0, FR_A, 20, 1000);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_bus", 32'(bus0), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_state", 32'(st0), 32'd1);
    chk("midrst_hum", 32'(hum0), 32'd0);
    @(negedge clk) reset = 1'b0;
    wait_cyc(300);
    chk("postrst_state", 32'(st0), 32'd1);
    chk("postrst_bus", 32'(bus0), 32'd1);
    do_read(0, 1'b1, FR_A, mk(16'd652, 16'd351, 0, 0), 1000, 0);

    mode1 = 1'b1;
    q1.push_back(mk(16'd652, 16'd351, 0, 0));
    pulse_start(1);
    chk("poll_busy_start", 32'(busy1), 32'd1);
    wait_cyc(5);
    pulse_start(1);
    sensor(1, FR_A, 99, 993);
    wait_done(1, 60, n);
    n = 0;
    while (n < 3000 && !(n > 20 && rd(1) === 1'b0)) begin
      @(negedge clk);
      n++;
      if (n == 20) drv(1, 1'b0);
    end
    chk_rng("poll_restart_delay", n, 1999, 2001);
    chk("poll_busy_auto", 32'(busy1), 32'd1);
    q1.push_back(mk(16'd652, 16'hFF9B, 0, 0));
    sensor(1, FR_B, 99, 1000);
    finish_read(1, 0);

    wait_cyc(50);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
